// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester (CPU / loader) arbiter in front of a single-port
// data memory. Each access takes three cycles: IDLE (sample and latch), BUSY
// (grant and drive memory), RESP (read data valid). Addresses above ADDR_LIMIT
// are not written, read back as zero, and flag addr_err.
// Optional build macro: DMEM_ARB_FIXED_PRIO_EN -- requester 0 always wins ties
// and the round-robin pointer is removed.
module dmem_arbiter #(
   parameter int ADDR_LIMIT = 65535
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        rvalid0,
   output logic        rvalid1,
   output logic [31:0] rdata,
   output logic        addr_err,
   output logic [31:0] read_address,
   output logic [31:0] write_address,
   output logic        write_enable,
   output logic [31:0] data_in,
   input  logic [31:0] data_out
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [31:0] ADDR_LIMIT_C = 32'(ADDR_LIMIT);

   state_t      state_r;
   state_t      state_nxt_s;

   // Latched copy of the winning request, valid from BUSY through RESP.
   logic        owner_r;
   logic        we_l_r;
   logic [31:0] addr_l_r;
   logic [31:0] wdata_l_r;

   // Arbitration result and the selected request fields.
   logic        any_req_s;
   logic        win_s;
   logic        sel_we_s;
   logic [31:0] sel_addr_s;
   logic [31:0] sel_wdata_s;
   logic        sel_oor_s;
   logic        lat_oor_s;

   // Next values for the registered outputs.
   logic        gnt0_nxt_s;
   logic        gnt1_nxt_s;
   logic        rvalid0_nxt_s;
   logic        rvalid1_nxt_s;
   logic        addr_err_nxt_s;
   logic        write_enable_nxt_s;
   logic [31:0] mem_addr_nxt_s;
   logic [31:0] data_in_nxt_s;

`ifndef DMEM_ARB_FIXED_PRIO_EN
   // Id of the requester granted most recently; resets to 1 so 0 wins first tie.
   logic        last_r;
`endif

   // Pick the winning requester for a sample taken in IDLE.
   always_comb begin
      any_req_s = req0 | req1;
      win_s     = 1'b0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
      if (req0) begin
         win_s = 1'b0;
      end else begin
         win_s = 1'b1;
      end
`else
      if (req0 && req1) begin
         win_s = ~last_r;
      end else if (req0) begin
         win_s = 1'b0;
      end else begin
         win_s = 1'b1;
      end
`endif
   end

   // Route the winner's request fields and classify its address.
   always_comb begin
      sel_we_s    = 1'b0;
      sel_addr_s  = 32'd0;
      sel_wdata_s = 32'd0;
      if (win_s) begin
         sel_we_s    = we1;
         sel_addr_s  = addr1;
         sel_wdata_s = wdata1;
      end else begin
         sel_we_s    = we0;
         sel_addr_s  = addr0;
         sel_wdata_s = wdata0;
      end
      sel_oor_s = (sel_addr_s > ADDR_LIMIT_C);
      lat_oor_s = (addr_l_r > ADDR_LIMIT_C);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic: IDLE -> BUSY on any request, then RESP, then IDLE.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (any_req_s) begin
               state_nxt_s = BUSY;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         BUSY:    state_nxt_s = RESP;
         RESP:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Latch the winning request (and advance the round-robin pointer) in IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         owner_r   <= 1'b0;
         we_l_r    <= 1'b0;
         addr_l_r  <= 32'd0;
         wdata_l_r <= 32'd0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
         last_r    <= 1'b1;
`endif
      end else if ((state_r == IDLE) && any_req_s) begin
         owner_r   <= win_s;
         we_l_r    <= sel_we_s;
         addr_l_r  <= sel_addr_s;
         wdata_l_r <= sel_wdata_s;
`ifndef DMEM_ARB_FIXED_PRIO_EN
         last_r    <= win_s;
`endif
      end else begin
         owner_r   <= owner_r;
         we_l_r    <= we_l_r;
         addr_l_r  <= addr_l_r;
         wdata_l_r <= wdata_l_r;
`ifndef DMEM_ARB_FIXED_PRIO_EN
         last_r    <= last_r;
`endif
      end
   end

   // Output values for the coming cycle. BUSY is only entered from IDLE, so
   // its memory controls come straight from the request being latched.
   always_comb begin
      gnt0_nxt_s         = 1'b0;
      gnt1_nxt_s         = 1'b0;
      rvalid0_nxt_s      = 1'b0;
      rvalid1_nxt_s      = 1'b0;
      addr_err_nxt_s     = 1'b0;
      write_enable_nxt_s = 1'b0;
      mem_addr_nxt_s     = 32'd0;
      data_in_nxt_s      = 32'd0;
      if ((state_r == IDLE) && (state_nxt_s == BUSY)) begin
         gnt0_nxt_s         = ~win_s;
         gnt1_nxt_s         = win_s;
         write_enable_nxt_s = sel_we_s & ~sel_oor_s;
         mem_addr_nxt_s     = sel_addr_s;
         data_in_nxt_s      = sel_wdata_s;
      end else if ((state_r == BUSY) && (state_nxt_s == RESP)) begin
         rvalid0_nxt_s  = ~we_l_r & ~owner_r;
         rvalid1_nxt_s  = ~we_l_r & owner_r;
         addr_err_nxt_s = lat_oor_s;
      end else begin
         gnt0_nxt_s = 1'b0;
      end
   end

   // Output registers; reset clears everything and aborts an access in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         gnt0          <= 1'b0;
         gnt1          <= 1'b0;
         rvalid0       <= 1'b0;
         rvalid1       <= 1'b0;
         addr_err      <= 1'b0;
         write_enable  <= 1'b0;
         read_address  <= 32'd0;
         write_address <= 32'd0;
         data_in       <= 32'd0;
      end else begin
         gnt0          <= gnt0_nxt_s;
         gnt1          <= gnt1_nxt_s;
         rvalid0       <= rvalid0_nxt_s;
         rvalid1       <= rvalid1_nxt_s;
         addr_err      <= addr_err_nxt_s;
         write_enable  <= write_enable_nxt_s;
         read_address  <= mem_addr_nxt_s;
         write_address <= mem_addr_nxt_s;
         data_in       <= data_in_nxt_s;
      end
   end

   // Capture read data at the end of BUSY; out-of-range reads return zero and
   // writes leave the last read value in place.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= 32'd0;
      end else if ((state_r == BUSY) && !we_l_r) begin
         if (lat_oor_s) begin
            rdata <= 32'd0;
         end else begin
            rdata <= data_out;
         end
      end else begin
         rdata <= rdata;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a small behavioural data memory.
module tb_dmem_arbiter;

   logic        clk;
   logic        rst;
   logic        req0, req1, we0, we1;
   logic [31:0] addr0, addr1, wdata0, wdata1;
   logic        gnt0, gnt1, rvalid0, rvalid1, addr_err, write_enable;
   logic [31:0] rdata, read_address, write_address, data_in, data_out;

   logic [31:0] mem [0:255];
   int          n_tests;
   int          n_fail;
   logic [31:0] exp_seq [0:3];

   dmem_arbiter #(.ADDR_LIMIT(65535)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata(rdata), .addr_err(addr_err),
      .read_address(read_address), .write_address(write_address),
      .write_enable(write_enable), .data_in(data_in), .data_out(data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: combinational read, write on rising edge (low 8 address bits).
   assign data_out = mem[read_address[7:0]];
   always @(posedge clk) begin
      if (write_enable) mem[write_address[7:0]] <= data_in;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".gnt0"}, {31'd0, gnt0}, 32'd0);
      chk({tag, ".gnt1"}, {31'd0, gnt1}, 32'd0);
      chk({tag, ".rvalid0"}, {31'd0, rvalid0}, 32'd0);
      chk({tag, ".rvalid1"}, {31'd0, rvalid1}, 32'd0);
      chk({tag, ".addr_err"}, {31'd0, addr_err}, 32'd0);
      chk({tag, ".write_enable"}, {31'd0, write_enable}, 32'd0);
      chk({tag, ".rdata"}, rdata, 32'd0);
      chk({tag, ".read_address"}, read_address, 32'd0);
      chk({tag, ".write_address"}, write_address, 32'd0);
      chk({tag, ".data_in"}, data_in, 32'd0);
   endtask

   // Single access from one requester, starting in an IDLE cycle.
   task automatic do_access(input string tag, input logic who, input logic we,
                            input logic [31:0] a, input logic [31:0] d,
                            input logic exp_we, input logic [31:0] exp_rdata,
                            input logic exp_err);
      if (who) begin
         req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
      end else begin
         req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
      end
      step();  // BUSY
      chk({tag, ".busy.gnt0"}, {31'd0, gnt0}, {31'd0, ~who});
      chk({tag, ".busy.gnt1"}, {31'd0, gnt1}, {31'd0, who});
      chk({tag, ".busy.we"}, {31'd0, write_enable}, {31'd0, exp_we});
      chk({tag, ".busy.waddr"}, write_address, a);
      chk({tag, ".busy.raddr"}, read_address, a);
      chk({tag, ".busy.din"}, data_in, d);
      chk({tag, ".busy.rvalid"}, {30'd0, rvalid1, rvalid0}, 32'd0);
      chk({tag, ".busy.err"}, {31'd0, addr_err}, 32'd0);
      req0 = 1'b0; req1 = 1'b0;
      step();  // RESP
      chk({tag, ".resp.gnt"}, {30'd0, gnt1, gnt0}, 32'd0);
      chk({tag, ".resp.rvalid0"}, {31'd0, rvalid0}, {31'd0, ~we & ~who});
      chk({tag, ".resp.rvalid1"}, {31'd0, rvalid1}, {31'd0, ~we & who});
      chk({tag, ".resp.rdata"}, rdata, exp_rdata);
      chk({tag, ".resp.err"}, {31'd0, addr_err}, {31'd0, exp_err});
      chk({tag, ".resp.we"}, {31'd0, write_enable}, 32'd0);
      chk({tag, ".resp.raddr"}, read_address, 32'd0);
      step();  // IDLE
      chk({tag, ".idle.rvalid"}, {30'd0, rvalid1, rvalid0}, 32'd0);
      chk({tag, ".idle.err"}, {31'd0, addr_err}, 32'd0);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE0000 | 32'(i);
      rst = 1'b1;
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = 32'd0; addr1 = 32'd0; wdata0 = 32'd0; wdata1 = 32'd0;

      // Reset state
      step();
      step();
      chk_all_zero("reset");
      rst = 1'b0;

      // Write 0xA5 to address 5, then read it back
      do_access("wr5", 1'b0, 1'b1, 32'd5, 32'h000000A5, 1'b1, 32'd0, 1'b0);
      chk("mem5", mem[5], 32'h000000A5);
      do_access("rd5", 1'b0, 1'b0, 32'd5, 32'd0, 1'b0, 32'h000000A5, 1'b0);

      // Out-of-range write and read by requester 1
      do_access("wr_oor", 1'b1, 1'b1, 32'd65536, 32'h00000001, 1'b0, 32'h000000A5, 1'b1);
      chk("mem0_untouched", mem[0], 32'hC0DE0000);
      do_access("rd_oor", 1'b1, 1'b0, 32'd65536, 32'd0, 1'b0, 32'd0, 1'b1);

      // Boundary address is in range
      do_access("wr_lim", 1'b1, 1'b1, 32'd65535, 32'h0000BEEF, 1'b1, 32'd0, 1'b0);
      chk("mem_ff", mem[255], 32'h0000BEEF);

      // A write leaves rdata unchanged; a following read picks up new data
      do_access("wr7", 1'b1, 1'b1, 32'd7, 32'h00000077, 1'b1, 32'd0, 1'b0);
      do_access("rd7", 1'b0, 1'b0, 32'd7, 32'd0, 1'b0, 32'h00000077, 1'b0);

      // Contention: both requesters held high for four accesses after reset
      rst = 1'b1;
      step();
      rst = 1'b0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
      exp_seq[0] = 32'd0; exp_seq[1] = 32'd0; exp_seq[2] = 32'd0; exp_seq[3] = 32'd0;
`else
      exp_seq[0] = 32'd0; exp_seq[1] = 32'd1; exp_seq[2] = 32'd0; exp_seq[3] = 32'd1;
`endif
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'd5;
      req1 = 1'b1; we1 = 1'b0; addr1 = 32'd7;
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("rr%0d.gnt", k), {30'd0, gnt1, gnt0},
             (exp_seq[k] == 32'd1) ? 32'd2 : 32'd1);
         step();
         chk($sformatf("rr%0d.rvalid", k), {30'd0, rvalid1, rvalid0},
             (exp_seq[k] == 32'd1) ? 32'd2 : 32'd1);
         chk($sformatf("rr%0d.rdata", k), rdata,
             (exp_seq[k] == 32'd1) ? 32'h00000077 : 32'h000000A5);
         step();
      end
      req0 = 1'b0; req1 = 1'b0;
      step();

      // Reset during BUSY of a read by requester 0 aborts it
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'd7;
      step();
      chk("abort.gnt0", {31'd0, gnt0}, 32'd1);
      req0 = 1'b0;
      rst  = 1'b1;
      step();
      chk_all_zero("abort");
      rst = 1'b0;
      step();
      chk_all_zero("abort_idle");

      // Tie after reset goes to requester 0
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'd7;
      req1 = 1'b1; we1 = 1'b0; addr1 = 32'd5;
      step();
      chk("tie.gnt", {30'd0, gnt1, gnt0}, 32'd1);
      req0 = 1'b0; req1 = 1'b0;
      step();
      chk("tie.rvalid", {30'd0, rvalid1, rvalid0}, 32'd1);
      chk("tie.rdata", rdata, 32'h00000077);
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_LIMIT, default 65535, highest word address accepted by data memory.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req0/req1  input  1  access request from requester 0 (CPU) / requester 1 (loader).
REQ-005 SHALL have ports we0/we1  input  1  1 = write, 0 = read, per requester.
REQ-006 SHALL have ports addr0/addr1  input  32  word address, per requester.
REQ-007 SHALL have ports wdata0/wdata1  input  32  write data, per requester.
REQ-008 SHALL have ports gnt0/gnt1  output  1  one-cycle grant pulse, per requester.
REQ-009 SHALL have ports rvalid0/rvalid1  output  1  one-cycle read-data-valid pulse, per requester.
REQ-010 SHALL have port rdata  output  32  registered read data, shared; qualified by rvalid0/rvalid1.
REQ-011 SHALL have port addr_err  output  1  one-cycle pulse: granted access had address > ADDR_LIMIT.
REQ-012 SHALL have ports read_address, write_address  output  32  data-memory addresses.
REQ-013 SHALL have ports write_enable  output  1, data_in  output  32  data-memory write controls.
REQ-014 SHALL have port data_out  input  32  data-memory combinational read data.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-016 IDLE: if any req sampled high, latch winner's we/addr/wdata and owner id, go BUSY; else stay IDLE.
REQ-017 BUSY: assert owner's gnt for exactly this cycle; drive memory from latched copy; go RESP.
REQ-018 RESP: pulse owner's rvalid if access was a read; register rdata from data_out at end of BUSY; go IDLE.
REQ-019 Latency: req high in IDLE cycle N -> gnt in N+1 -> rvalid/rdata in N+2; next request sampled N+3; max throughput one access per 3 cycles.
REQ-020 Requester SHALL hold req/we/addr/wdata stable until gnt; arbiter ignores changes after latch; req deasserted before sample is a no-request.
REQ-021 Arbitration: both req in IDLE -> grant requester not granted most recently (round robin); single req -> that requester.
REQ-022 write_enable SHALL be 1 only in BUSY, only for a write with latched addr <= ADDR_LIMIT.
REQ-023 Outside BUSY: read_address, write_address, data_in = 0, write_enable = 0.
REQ-024 BUSY: read_address = write_address = latched addr; data_in = latched wdata.
REQ-025 Address > ADDR_LIMIT: write suppressed, read returns rdata = 0, addr_err pulses in RESP; gnt/rvalid still issued normally.
REQ-026 rdata SHALL hold last value until next read completes; write accesses leave rdata unchanged.
REQ-027 At most one of gnt0/gnt1, and at most one of rvalid0/rvalid1, high in any cycle.

Reset
REQ-028 rst high at a clock edge SHALL force state IDLE, round-robin pointer to "requester 1 last" (requester 0 wins first tie).
REQ-029 During and after reset: gnt0, gnt1, rvalid0, rvalid1, addr_err, write_enable = 0; rdata, read_address, write_address, data_in = 0.
REQ-030 rst during BUSY SHALL abort access: no rvalid, no further write cycle; requester must re-request.

Configuration
REQ-031 Macro DMEM_ARB_FIXED_PRIO_EN defined: requester 0 always wins ties, round-robin pointer omitted.
REQ-032 Macro DMEM_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-021; all other behaviour identical.

Verification
REQ-033 Reset -> all outputs 0; req0=1, we0=1, addr0=5, wdata0=0xA5 -> gnt0 cycle 1, write_enable=1 with write_address=5 in same cycle, mem[5]=0xA5.
REQ-034 req0 read addr0=5 after REQ-033 -> gnt0 at N+1, rvalid0 at N+2, rdata=0xA5, addr_err=0.
REQ-035 req0 and req1 both held high for 4 accesses -> grants alternate 0,1,0,1 (fixed-prio build: 0,0,0,0 while req0 held).
REQ-036 req1 write addr1=65536, wdata=0x1 -> gnt1, write_enable stays 0, addr_err pulses at N+2; read addr 65536 -> rdata=0, rvalid1, addr_err.
REQ-037 rst asserted in BUSY of a read -> no rvalid; next cycle all outputs 0, state IDLE, tie goes to requester 0.
